// File: rtl/nios_system_onchip_mem_arbiter_pkg.sv
// Shared constants for the two-master on-chip RAM arbiter: owner state
// encoding, default bus widths and the hold-counter width helper.
package nios_system_mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 11;
    localparam int unsigned DATA_W_DEF = 32;

    // Owner state encoding (IDLE / OWN0 / OWN1)
    typedef logic [1:0] owner_t;
    localparam owner_t ST_IDLE = 2'd0;
    localparam owner_t ST_OWN0 = 2'd1;
    localparam owner_t ST_OWN1 = 2'd2;

    // Counter holds 0..max_hold-1; a single bit still needed when max_hold = 1
    function automatic int unsigned hold_w(input int unsigned max_hold);
        return (max_hold > 1) ? $clog2(max_hold) : 1;
    endfunction

endpackage

// File: rtl/nios_system_onchip_mem_arbiter_if.sv
// Avalon-MM bundle between two requesters, the arbiter and the RAM s1 port.
// slave = arbiter side, master = requester/RAM environment side.
interface nios_system_onchip_mem_arbiter_if
    import nios_system_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] m0_address;
    logic [BE_W-1:0]   m0_byteenable;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;

    logic [ADDR_W-1:0] m1_address;
    logic [BE_W-1:0]   m1_byteenable;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;

    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken,
        input  mem_readdata
    );

    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken,
        output mem_readdata
    );

endinterface

// File: rtl/nios_system_rr_arb2.sv
// Two-requester round-robin arbiter with bounded hold. Grant is combinational
// from the owner state and requests; the owner register follows the grant.
module nios_system_rr_arb2
    import nios_system_mem_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant_c
);
    localparam int unsigned        HOLD_W   = hold_w(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    owner_t            r_state;
    owner_t            w_state_nxt;
    logic              r_last_grant;
    logic              w_last_grant_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;
    logic [1:0]        w_grant;
    logic              w_hold_done;

    assign w_hold_done = (r_hold_cnt == HOLD_MAX);
    assign o_grant_c   = w_grant;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_hold_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
        end
    end

    always_comb begin
        w_grant          = 2'b00;
        w_state_nxt      = ST_IDLE;
        w_last_grant_nxt = r_last_grant;
        w_hold_cnt_nxt   = '0;

        // Owner keeps the port unless the other side waits and the hold is used up
        case (r_state)
            ST_OWN0: begin
                if (i_req[0] && !(i_req[1] && w_hold_done)) w_grant = 2'b01;
                else if (i_req[1])                          w_grant = 2'b10;
            end
            ST_OWN1: begin
                if (i_req[1] && !(i_req[0] && w_hold_done)) w_grant = 2'b10;
                else if (i_req[0])                          w_grant = 2'b01;
            end
            default: begin
                if (&i_req) w_grant = r_last_grant ? 2'b01 : 2'b10;
                else        w_grant = i_req;
            end
        endcase

        if (w_grant[0]) begin
            w_state_nxt      = ST_OWN0;
            w_last_grant_nxt = 1'b0;
        end else if (w_grant[1]) begin
            w_state_nxt      = ST_OWN1;
            w_last_grant_nxt = 1'b1;
        end

        // Count only transfers that continue the same ownership
        if ((w_grant != 2'b00) && (w_state_nxt == r_state))
            w_hold_cnt_nxt = w_hold_done ? r_hold_cnt : r_hold_cnt + HOLD_W'(1);
    end

endmodule

// File: rtl/nios_system_onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM between two Avalon-MM masters: command
// mux to s1, per-master waitrequest and one-cycle readdatavalid return.
module nios_system_onchip_mem_arbiter
    import nios_system_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic clk,
    input  logic reset_n,
    nios_system_onchip_mem_arbiter_if.slave bus
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic [1:0]        w_acc;
    logic [1:0]        w_rd_acc;
    logic [1:0]        r_rd_pend;
    logic [ADDR_W-1:0] w_address;
    logic [BE_W-1:0]   w_byteenable;
    logic [DATA_W-1:0] w_writedata;
    logic              w_write;

    assign w_req = {bus.m1_read | bus.m1_write, bus.m0_read | bus.m0_write};

    nios_system_rr_arb2 #(
        .MAX_HOLD (MAX_HOLD)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (w_req),
        .o_grant_c (w_grant)
    );

    // Nothing is accepted while reset is asserted
    assign w_acc    = w_grant & {2{reset_n}};
    assign w_rd_acc = w_acc & {bus.m1_read & ~bus.m1_write,
                               bus.m0_read & ~bus.m0_write};

    always_ff @(posedge clk) begin
        if (!reset_n) r_rd_pend <= 2'b00;
        else          r_rd_pend <= w_rd_acc;
    end

    always_comb begin
        w_address    = '0;
        w_byteenable = '0;
        w_writedata  = '0;
        w_write      = 1'b0;
        if (w_acc[0]) begin
            w_address    = bus.m0_address;
            w_byteenable = bus.m0_byteenable;
            w_writedata  = bus.m0_writedata;
            w_write      = bus.m0_write;
        end else if (w_acc[1]) begin
            w_address    = bus.m1_address;
            w_byteenable = bus.m1_byteenable;
            w_writedata  = bus.m1_writedata;
            w_write      = bus.m1_write;
        end
    end

    assign bus.mem_address    = w_address;
    assign bus.mem_byteenable = w_byteenable;
    assign bus.mem_writedata  = w_writedata;
    assign bus.mem_write      = w_write;
    assign bus.mem_chipselect = |w_acc;
    assign bus.mem_clken      = 1'b1;

    assign bus.m0_waitrequest   = ~w_acc[0];
    assign bus.m1_waitrequest   = ~w_acc[1];
    assign bus.m0_readdatavalid = r_rd_pend[0] & reset_n;
    assign bus.m1_readdatavalid = r_rd_pend[1] & reset_n;
    assign bus.m0_readdata      = bus.mem_readdata;
    assign bus.m1_readdata      = bus.mem_readdata;

endmodule

// File: doc/nios_system_onchip_mem_arbiter.md
Name: nios_system_onchip_mem_arbiter

Overview:
Two-port Avalon-MM arbiter that shares the single-port on-chip RAM (2048 x 32, byte-enabled, one-cycle read latency) between two requesters, e.g. the Nios data master and a DMA master. It sits between the requesters and the RAM slave's s1 interface. It grants round-robin with a bounded hold, issues one transfer per cycle, and routes read data back with readdatavalid.

Parameters:
ADDR_W, 11, word address width (2048 words)
DATA_W, 32, data width; BE_W = DATA_W/8 (derived, not overridable)
MAX_HOLD, 4, maximum consecutive granted transfers per master while the other is requesting (1..15)

Ports:
clk  in  1  single clock
reset_n  in  1  synchronous, active-low reset
m0_address  in  ADDR_W  master 0 word address
m0_byteenable  in  BE_W  master 0 byte enables
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  DATA_W  master 0 write data
m0_waitrequest  out  1  high = master 0 request not accepted this cycle
m0_readdata  out  DATA_W  master 0 read data
m0_readdatavalid  out  1  master 0 read data valid
m1_*  same set as m0_*, for master 1
mem_address  out  ADDR_W  to RAM address
mem_byteenable  out  BE_W  to RAM byteenable
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_writedata  out  DATA_W  to RAM writedata
mem_clken  out  1  to RAM clken; tied 1
mem_readdata  in  DATA_W  from RAM readdata

Behaviour:
- Request: reqN = mN_read | mN_write. If a master raises both, it is a write; the read is ignored and gets no readdatavalid.
- FSM states: IDLE, OWN0, OWN1, held in a registered owner state. Grant is combinational from the current state and requests; the state register takes the next owner.
- IDLE: one requester wins. If both request, the master not in last_grant wins. last_grant resets to 1, so m0 wins first.
- OWNn: stay while reqn = 1, unless the other master is requesting and hold_cnt = MAX_HOLD-1; then switch to the other master.
- OWNn with reqn = 0: switch to the other master if it is requesting, else go to IDLE.
- A granted master has the grant in the same cycle it requests; no idle bubble on a switch.
- hold_cnt: clears on any owner change or in IDLE, increments per accepted transfer, saturates at MAX_HOLD-1.
- Accepted cycle: mN_waitrequest = 0 for the winner and 1 for the loser. mem_* are driven from the winner's inputs with mem_chipselect = 1 and mem_write = winner write.
- No grant: mem_chipselect = 0, mem_write = 0, mem_address/byteenable/writedata = 0. A master that is not requesting sees waitrequest = 1.
- Read return: an accepted read in cycle N gives mN_readdatavalid = 1 in cycle N+1. The valid flag comes from a registered rd_pend[1:0].
- mN_readdata = mem_readdata in every cycle; masters qualify it with valid. Back-to-back reads (either master, any interleave) give one valid per cycle, in order.
- Writes: accepted in one cycle; no response.
- Reset (reset_n = 0 at a clk edge): state = IDLE, last_grant = 1, hold_cnt = 0, rd_pend = 0.
  - While reset_n = 0: both waitrequest = 1, both readdatavalid = 0, mem_chipselect = 0, mem_write = 0, mem_clken = 1.
  - A read accepted in the cycle before reset loses its valid.
- MAX_HOLD = 1: strict alternation under contention.

Decomposition:
- Package nios_system_mem_arb_pkg: owner state enum (IDLE/OWN0/OWN1), ADDR_W/DATA_W defaults, hold-counter width = clog2(MAX_HOLD).
- Sub-module nios_system_rr_arb2: 2-requester round-robin with hold counter. Outputs a one-hot grant and updates last_grant. The top level holds the datapath muxing and rd_pend.

Test Plan:
- Reset → both waitrequest = 1, readdatavalid = 0, mem_chipselect = 0; after release, single m0 write addr 0x005 data 0xDEADBEEF be 0xF → mem_write = 1 the same cycle, m0_waitrequest = 0.
- m0 read addr 0x005 at cycle N → m0_readdatavalid = 1 at N+1 with readdata 0xDEADBEEF; m1 valid stays 0.
- m0 and m1 both hold read continuously, MAX_HOLD = 4 → grants m0 x4, m1 x4, m0 x4...; readdatavalid follows each master's grant pattern one cycle later.
- Simultaneous first requests after reset → m0 wins; next contention after m0 idles goes to m1.
- m1 write be 0x3 data 0x0000AAAA to addr 0x7FF (top word), then m1 read → readdata[15:0] = 0xAAAA, upper bytes unchanged.
- m0 read accepted, reset_n = 0 next cycle → no m0_readdatavalid; the FSM is in IDLE after reset.
